// File: rtl/fmul_result_stage.sv
// Result stage after the single-precision multiplier: special-operand fix-up,
// per-op exception flags, a small result FIFO and the sticky fflags accumulator.
module fmul_result_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_prod,
  input  logic        in_inexact,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [4:0]  FLAG_NV = 5'b10000;
  localparam logic [4:0]  FLAG_OF = 5'b00100;
  localparam logic [4:0]  FLAG_UF = 5'b00010;
  localparam logic [4:0]  FLAG_NX = 5'b00001;

  // Operand classification
  logic [7:0]  a_exp, b_exp, p_exp;
  logic [22:0] a_man, b_man;
  logic        sign;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [8:0]  esum;

  assign a_exp  = in_a[30:23];
  assign b_exp  = in_b[30:23];
  assign p_exp  = in_prod[30:23];
  assign a_man  = in_a[22:0];
  assign b_man  = in_b[22:0];
  assign sign   = in_a[31] ^ in_b[31];
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);
  assign a_snan = a_nan && !a_man[22];
  assign b_snan = b_nan && !b_man[22];
  assign esum   = {1'b0, a_exp} + {1'b0, b_exp};

  // The product sign bit is always replaced by the operand sign.
  logic unused_prod_sign;
  assign unused_prod_sign = in_prod[31];

  logic [31:0] fix_result;
  logic [4:0]  fix_flags;

  always_comb begin
    fix_result = {sign, in_prod[30:0]};
    fix_flags  = in_inexact ? FLAG_NX : 5'b0;
    if (a_nan || b_nan) begin
      fix_result = QNAN;
      fix_flags  = (a_snan || b_snan) ? FLAG_NV : 5'b0;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      fix_result = QNAN;
      fix_flags  = FLAG_NV;
    end else if (a_inf || b_inf) begin
      fix_result = {sign, 8'hFF, 23'd0};
      fix_flags  = 5'b0;
    end else if (a_zero || b_zero) begin
      fix_result = {sign, 31'd0};
      fix_flags  = 5'b0;
    end else if ((esum >= 9'd382) || (p_exp == 8'hFF)) begin
      fix_result = {sign, 8'hFF, 23'd0};
      fix_flags  = FLAG_OF | FLAG_NX;
    end else if ((esum <= 9'd126) || (p_exp == 8'h00)) begin
      fix_result = {sign, 31'd0};
      fix_flags  = FLAG_UF | FLAG_NX;
    end
  end

  // Result FIFO
  logic [36:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             full, push, pop;
  logic [36:0]      head;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  assign out_result = out_valid ? head[31:0]  : 32'd0;
  assign out_flags  = out_valid ? head[36:32] : 5'd0;
  assign fflags     = fflags_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flags accrue only when an entry retires.
    fflags_d = (fflags_clr ? 5'd0 : fflags_q) | (pop ? out_flags : 5'd0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fix_flags, fix_result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fmul_result_stage.sv
// Bench for fmul_result_stage: directed vector table, hand sequences for
// backpressure / sticky flags / async reset, and a randomized scoreboard run.
module tb_fmul_result_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0, in_prod = '0;
  logic        in_inexact = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;

  fmul_result_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_prod    (in_prod),
    .in_inexact (in_inexact),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, p;
    logic        nx;
    logic [31:0] r;
    logic [4:0]  f;
  } vec_t;

  vec_t        vecs [15];
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  exp_ff = '0;
  logic [36:0] q [$];
  logic [36:0] head;
  logic        drain, do_pop, do_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic nx);
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    in_prod    = p;
    in_inexact = nx;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic nx);
    drive(a, b, p, nx);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic clear_ff();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    exp_ff = '0;
    chk("ff_clear", fflags, 0);
  endtask

  // Reference: classify 0=zero/subnormal 1=normal 2=inf 3=qNaN 4=sNaN
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'd0)   return 0;
    if (x[30:23] != 8'd255) return 1;
    if (x[22:0] == 23'd0)   return 2;
    return x[22] ? 3 : 4;
  endfunction

  function automatic logic [36:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] p, input logic nx);
    logic s;
    int   ca, cb, e;
    s  = a[31] ^ b[31];
    ca = cls(a);
    cb = cls(b);
    if (ca >= 3 || cb >= 3) return {((ca == 4 || cb == 4) ? 5'h10 : 5'h00), 32'h7FC0_0000};
    if ((ca == 2 && cb == 0) || (ca == 0 && cb == 2)) return {5'h10, 32'h7FC0_0000};
    if (ca == 2 || cb == 2) return {5'h00, s, 8'hFF, 23'd0};
    if (ca == 0 || cb == 0) return {5'h00, s, 31'd0};
    // Unbiased exponent sum of the exact product
    e = (int'(a[30:23]) - 127) + (int'(b[30:23]) - 127);
    if (e >= 128 || p[30:23] == 8'hFF) return {5'h05, s, 8'hFF, 23'd0};
    if (e <= -128 || p[30:23] == 8'h00) return {5'h03, s, 31'd0};
    return {4'b0, nx, s, p[30:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'h01;
      3: e = 8'hFE;
      4: e = 8'h7F;
      default: e = 8'($urandom_range(0, 255));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom());
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  function automatic logic [31:0] rnd_prod();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0: e = 8'h00;
      1: e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom())};
  endfunction

  initial begin
    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 32'h40C00000, 5'h00};
    vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h12345678, 1'b0, 32'h7FC00000, 5'h10};
    vecs[2]  = '{32'h7F800001, 32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 5'h10};
    vecs[3]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1, 32'h7FC00000, 5'h00};
    vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h12345678, 1'b0, 32'h7F800000, 5'h05};
    vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 32'h00000000, 5'h03};
    vecs[6]  = '{32'h80800000, 32'h00800000, 32'h00000000, 1'b0, 32'h80000000, 5'h03};
    vecs[7]  = '{32'h3FC00000, 32'hC0000000, 32'h40400000, 1'b1, 32'hC0400000, 5'h01};
    vecs[8]  = '{32'h00000001, 32'hBF800000, 32'h00000001, 1'b1, 32'h80000000, 5'h00};
    vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'h7F800000, 1'b0, 32'hFF800000, 5'h00};
    vecs[10] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 32'h7F000000, 5'h00};
    vecs[11] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0, 32'h7F800000, 5'h05};
    vecs[12] = '{32'h00800000, 32'h3F000000, 32'h00800000, 1'b0, 32'h00800000, 5'h00};
    vecs[13] = '{32'h00800000, 32'h3E800000, 32'h00400000, 1'b0, 32'h00000000, 5'h03};
    vecs[14] = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 5'h05};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_fflags", fflags, 0);
    #20 rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);
    tick();

    // Directed table, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nx);
      chk("vec_no_bypass", out_valid, 0);
      tick();
      in_valid = 1'b0;
      chk("vec_valid", out_valid, 1);
      chk("vec_result", out_result, vecs[i].r);
      chk("vec_flags", out_flags, vecs[i].f);
      $display("vec %0d a=%h b=%h prod=%h nx=%b -> result=%h flags=%h",
               i, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nx, out_result, out_flags);
      tick();
      exp_ff = exp_ff | vecs[i].f;
      chk("vec_drained", out_valid, 0);
      chk("vec_fflags", fflags, exp_ff);
    end

    // Backpressure: three ops, only two fit
    clear_ff();
    out_ready = 1'b0;
    drive(32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    chk("bp_ready0", in_ready, 1);
    tick();
    drive(32'h7F000000, 32'h7F000000, 32'h12345678, 1'b0);
    chk("bp_ready1", in_ready, 1);
    tick();
    drive(32'h7F800000, 32'h00000000, 32'h00000000, 1'b0);
    chk("bp_ready2", in_ready, 0);
    tick();
    chk("bp_held_ready", in_ready, 0);
    chk("bp_head0", out_result, 32'h40C00000);
    chk("bp_head0_stable", out_flags, 5'h01);
    chk("bp_no_accrue", fflags, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_head1", out_result, 32'h7F800000);
    chk("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_head2", out_result, 32'h7FC00000);
    chk("bp_head2_flags", out_flags, 5'h10);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_fflags", fflags, 5'h15);
    $display("backpressure: 3 ops retired in order, fflags=%h", fflags);

    // Sticky accumulation and clear-with-pop
    clear_ff();
    push_one(32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    chk("sticky_nx", fflags, 5'h01);
    push_one(32'h7F000000, 32'h7F000000, 32'h00000000, 1'b0);
    chk("sticky_of", fflags, 5'h05);
    out_ready = 1'b0;
    drive(32'h00800000, 32'h00800000, 32'h00000000, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("sticky_uf_head", out_flags, 5'h03);
    out_ready  = 1'b1;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    exp_ff = 5'h03;
    chk("sticky_clr_pop", fflags, 5'h03);
    chk("sticky_empty", out_valid, 0);
    $display("sticky: clear with pop leaves fflags=%h", fflags);

    // Randomized run against the reference model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      drain      = (c >= 590);
      in_valid   = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_a       = rnd_op();
      in_b       = rnd_op();
      in_prod    = rnd_prod();
      in_inexact = 1'($urandom_range(0, 1));
      out_ready  = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      fflags_clr = !drain && ($urandom_range(0, 15) == 0);
      #3;
      head = (q.size() != 0) ? q[0] : 37'd0;
      chk("rnd_in_ready", in_ready, (q.size() < DEPTH));
      chk("rnd_out_valid", out_valid, (q.size() != 0));
      chk("rnd_result", out_result, head[31:0]);
      chk("rnd_flags", out_flags, head[36:32]);
      chk("rnd_fflags", fflags, exp_ff);
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH);
      exp_ff  = (fflags_clr ? 5'd0 : exp_ff) | (do_pop ? head[36:32] : 5'd0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(ref_op(in_a, in_b, in_prod, in_inexact));
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    fflags_clr = 1'b0;
    $display("random: 600 cycles, %0d entries left in model", q.size());

    // Asynchronous reset with buffered entries
    clear_ff();
    out_ready = 1'b1;
    push_one(32'h7F800000, 32'h00000000, 32'h00000000, 1'b0);
    chk("rst_pre_fflags", fflags, 5'h10);
    out_ready = 1'b0;
    drive(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    tick();
    drive(32'h3FC00000, 32'hC0000000, 32'h40400000, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_fflags", fflags, 0);
    chk("rst_async_ready", in_ready, 0);
    chk("rst_async_result", out_result, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_rel_ready", in_ready, 1);
    chk("rst_rel_valid", out_valid, 0);
    tick();
    out_ready = 1'b1;
    drive(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    chk("rst_post_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("rst_post_valid", out_valid, 1);
    chk("rst_post_result", out_result, 32'h40C00000);
    tick();
    chk("rst_post_fflags", fflags, 0);
    $display("reset: buffered entries discarded, post-reset op result=40c00000");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
